game_ctrl_fsm: RTL and testbench
================================

Name: game_ctrl_fsm

Overview:
Second-generation snake game controller. It sequences the game through IDLE, RUN, PAUSE, DYING and GAMEOVER, and generates a speed-scaled frame tick whose period shrinks as the level rises. It also buffers direction requests in a small anti-reversal queue and tracks score, level and lives. It sits between the PS2 decoder and collision detector on the input side, and the snake datapath and score display on the output side.

Parameters:
- BASE_TICKS, 20_000_000: frame period at level 0, in clk cycles.
- MIN_TICKS, 5_000_000: floor on frame period.
- STEP_TICKS, 1_500_000: period reduction per level.
- FOOD_PER_LEVEL, 5: foods eaten per level increment.
- MAX_LEVEL, 15: level saturation value.
- LIVES, 3: lives at game start (≥1).
- RESPAWN_FRAMES, 8: frames spent in DYING.
- SCORE_W, 10: score width.
- CNT_W, 25: tick counter width; must hold BASE_TICKS-1.

Ports:
- clk, input, 1: system clock.
- rstn, input, 1: asynchronous active-low reset.
- start_btn, input, 1: 1-cycle pulse; start or acknowledge game over.
- pause_btn, input, 1: 1-cycle pulse; toggle pause.
- dir_valid, input, 1: 1-cycle pulse; new direction request.
- dir_in, input, 2: requested direction (00 up, 01 right, 10 down, 11 left).
- food_eaten, input, 1: from collision detector; may be a pulse at any time.
- collision, input, 1: from collision detector; sampled on frame_tick.
- frame_tick, output, 1: 1-cycle pulse per frame while RUN.
- update_snake, output, 1: pulse; advance snake (equals frame_tick in RUN).
- score_inc, output, 1: pulse; food credited.
- reset_game, output, 1: 1-cycle pulse; reinitialise snake/food.
- respawn, output, 1: 1-cycle pulse; re-place snake after a life is lost.
- direction_out, output, 2: current committed direction.
- score, output, SCORE_W: saturating score.
- level, output, 4: current level.
- lives_left, output, 2: remaining lives.
- state_out, output, 3: current state, for display.

Behaviour:
- Reset (async, rstn=0): state=IDLE; all pulses 0; direction_out=01; score=0; level=0; lives_left=LIVES; tick counter=0; queue empty; eaten latch=0.
- All outputs are registered. Pulses are high for exactly one clk.
- IDLE, on start_btn: reset_game=1 next cycle; score, level and queue cleared; lives_left=LIVES; direction_out=01; counter=0; go to RUN.
- RUN:
  - Counter increments each cycle. On reaching period-1 it wraps to 0 and frame_tick=update_snake=1 next cycle.
  - period = max(BASE_TICKS - level*STEP_TICKS, MIN_TICKS), recomputed only at wrap.
  - Pop queue head into direction_out in the same cycle frame_tick is asserted.
- Food latch: set by food_eaten in any state; cleared on a frame_tick. On a RUN frame_tick with the latch set:
  - score_inc=1 and score+1, saturating at all-ones.
  - Every FOOD_PER_LEVEL credits, level+1, saturating at MAX_LEVEL.
- Collision, sampled only on a RUN frame_tick:
  - Takes priority over food: score_inc suppressed, latch cleared.
  - If lives_left>1: decrement lives_left and go to DYING.
  - Otherwise: lives_left=0 and go to GAMEOVER.
- DYING:
  - Counter keeps running at the current period; frame_tick stays 0.
  - After RESPAWN_FRAMES wraps: respawn=1, queue flushed, direction_out=01, return to RUN with counter=0.
- PAUSE:
  - pause_btn in RUN → PAUSE; pause_btn in PAUSE → RUN.
  - In PAUSE the counter is held and no pulses are issued; queue pushes are still accepted.
  - pause_btn in any other state is ignored.
- GAMEOVER: outputs held, score frozen. start_btn → IDLE.
- start_btn in RUN, PAUSE or DYING is ignored.
- Direction queue (depth 2):
  - On dir_valid, compare dir_in against the reference: tail entry if the queue is non-empty, else direction_out.
  - Reject dir_in if it equals the reference or is its reverse (dir_in == ref ^ 2'b10).
  - Reject if the queue is full; rejected requests are dropped silently.
  - Push and pop in the same cycle are both performed; the push is compared against the post-pop tail.
- pause_btn and frame-counter wrap in the same cycle: the pause wins and no frame_tick is issued.

Decomposition:
- game_pkg holds:
  - State encoding: IDLE=0, RUN=1, PAUSE=2, DYING=3, GAMEOVER=4.
  - Direction codes and the reverse function (xor 2'b10).
  - Default direction 01.
- dir_queue is a sub-module: 2-entry FIFO with reversal/duplicate filter and flush input.
- Period computation and score/level counters stay in the top level.

Test Plan:
Bench parameters for all cases: BASE=10, MIN=4, STEP=2, FOOD_PER_LEVEL=2, LIVES=2, RESPAWN_FRAMES=2.
1. Start and tick spacing: start_btn → reset_game pulse, then frame_tick every 10 cycles; direction_out=01; lives_left=2.
2. Level speed-up: food_eaten before each of 2 frames → 2 score_inc pulses, score=2, level=1, frame spacing becomes 8 from the next wrap. At level 3 spacing is 4; at level 4 it stays 4.
3. Direction queue: with direction_out=01, push 11 → rejected. Push 00 then 11 → both queued; next two ticks give 00 then 11. A third push while full is dropped.
4. Collision with food in the same frame: collision plus food latched on a tick → no score_inc, lives_left=1, DYING. After 2 frame wraps, respawn pulse, back to RUN, direction_out=01.
5. Last-life collision: second collision → lives_left=0, GAMEOVER, no further ticks. start_btn → IDLE. Second start_btn → score=0, lives_left=2.
6. Pause mid-frame and async reset: pause_btn at counter=5, hold 50 cycles, pause_btn again → next frame_tick 5 cycles later. rstn low mid-RUN → all outputs at reset values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the snake game controller: state encoding,
// direction codes and the reversal helper.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StPause    = 3'd2,
    StDying    = 3'd3,
    StGameover = 3'd4
  } state_e;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP      = 2'b00;
  localparam dir_t DIR_RIGHT   = 2'b01;
  localparam dir_t DIR_DOWN    = 2'b10;
  localparam dir_t DIR_LEFT    = 2'b11;
  localparam dir_t DIR_DEFAULT = DIR_RIGHT;

  function automatic dir_t reverse_dir(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Two-entry direction FIFO that drops duplicates and 180-degree reversals
// relative to the most recent direction the snake will be heading.
module dir_queue
  import game_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  dir_t din,
  input  logic pop,
  input  logic flush,
  input  dir_t cur_dir,
  output dir_t head,
  output logic valid
);

  logic [1:0]      cnt_q, cnt_d, post_cnt;
  dir_t [1:0]      ent_q, ent_d;
  dir_t            ref_dir;
  logic            accept;

  always_comb begin
    ent_d    = ent_q;
    post_cnt = cnt_q;
    // The post-pop tail equals the pre-pop tail, except when the popped head
    // becomes the new committed direction; both cases resolve to this mux.
    ref_dir  = (cnt_q == 2'd0) ? cur_dir : ((cnt_q == 2'd2) ? ent_q[1] : ent_q[0]);
    if (pop && (cnt_q != 2'd0)) begin
      ent_d[0] = ent_q[1];
      post_cnt = cnt_q - 2'd1;
    end
    cnt_d  = post_cnt;
    accept = push && (post_cnt != 2'd2) && (din != ref_dir) && (din != reverse_dir(ref_dir));
    if (accept) begin
      ent_d[post_cnt[0]] = din;
      cnt_d              = post_cnt + 2'd1;
    end
    if (flush) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 2'd0;
      ent_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign head  = ent_q[0];
  assign valid = (cnt_q != 2'd0);

endmodule

// File: rtl/game_ctrl_fsm.sv
// Snake game sequencer: state machine, level-scaled frame tick, food/score/level
// bookkeeping, lives and respawn handling.
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int unsigned BASE_TICKS     = 20_000_000,
  parameter int unsigned MIN_TICKS      = 5_000_000,
  parameter int unsigned STEP_TICKS     = 1_500_000,
  parameter int unsigned FOOD_PER_LEVEL = 5,
  parameter int unsigned MAX_LEVEL      = 15,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned RESPAWN_FRAMES = 8,
  parameter int unsigned SCORE_W        = 10,
  parameter int unsigned CNT_W          = 25
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               dir_valid,
  input  logic [1:0]         dir_in,
  input  logic               food_eaten,
  input  logic               collision,
  output logic               frame_tick,
  output logic               update_snake,
  output logic               score_inc,
  output logic               reset_game,
  output logic               respawn,
  output logic [1:0]         direction_out,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic [1:0]         lives_left,
  output logic [2:0]         state_out
);

  localparam int unsigned FOOD_W = $clog2(FOOD_PER_LEVEL + 1);
  localparam int unsigned DIE_W  = $clog2(RESPAWN_FRAMES + 1);

  function automatic logic [CNT_W-1:0] calc_period(input logic [3:0] lvl);
    int unsigned dec;
    dec = 32'(lvl) * STEP_TICKS;
    if (dec + MIN_TICKS >= BASE_TICKS) return CNT_W'(MIN_TICKS);
    return CNT_W'(BASE_TICKS - dec);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         level_q, level_d;
  logic [1:0]         lives_q, lives_d;
  logic [FOOD_W-1:0]  food_cnt_q, food_cnt_d;
  logic [DIE_W-1:0]   die_q, die_d;
  dir_t               dir_q, dir_d;
  logic               eaten_q, eaten_d;
  logic               tick_q, tick_d, inc_q, inc_d, rst_game_q, rst_game_d, respawn_q, respawn_d;
  logic               wrap, q_pop, q_flush, q_valid;
  dir_t               q_head;

  dir_queue u_dir_queue (
    .clk    (clk),
    .rstn   (rstn),
    .push   (dir_valid),
    .din    (dir_in),
    .pop    (q_pop),
    .flush  (q_flush),
    .cur_dir(dir_q),
    .head   (q_head),
    .valid  (q_valid)
  );

  assign wrap = (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    score_d    = score_q;
    level_d    = level_q;
    lives_d    = lives_q;
    food_cnt_d = food_cnt_q;
    die_d      = die_q;
    dir_d      = dir_q;
    eaten_d    = eaten_q | food_eaten;
    tick_d     = 1'b0;
    inc_d      = 1'b0;
    rst_game_d = 1'b0;
    respawn_d  = 1'b0;
    q_pop      = 1'b0;
    q_flush    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_btn) begin
          state_d    = StRun;
          rst_game_d = 1'b1;
          score_d    = '0;
          level_d    = '0;
          food_cnt_d = '0;
          lives_d    = 2'(LIVES);
          dir_d      = DIR_DEFAULT;
          cnt_d      = '0;
          period_d   = CNT_W'(BASE_TICKS);
          q_flush    = 1'b1;
          // A food seen before the game started must not be credited.
          eaten_d    = food_eaten;
        end
      end
      StRun: begin
        if (pause_btn) begin
          state_d = StPause;
        end else if (wrap) begin
          cnt_d    = '0;
          period_d = calc_period(level_q);
          tick_d   = 1'b1;
          eaten_d  = food_eaten;
          if (q_valid) begin
            q_pop = 1'b1;
            dir_d = q_head;
          end
          if (collision) begin
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              die_d   = '0;
              state_d = StDying;
            end else begin
              lives_d = 2'd0;
              state_d = StGameover;
            end
          end else if (eaten_q) begin
            inc_d = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
            if (food_cnt_q == FOOD_W'(FOOD_PER_LEVEL - 1)) begin
              food_cnt_d = '0;
              if (level_q != 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
            end else begin
              food_cnt_d = food_cnt_q + FOOD_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPause: begin
        if (pause_btn) state_d = StRun;
      end
      StDying: begin
        if (wrap) begin
          cnt_d    = '0;
          period_d = calc_period(level_q);
          if (die_q == DIE_W'(RESPAWN_FRAMES - 1)) begin
            respawn_d = 1'b1;
            q_flush   = 1'b1;
            dir_d     = DIR_DEFAULT;
            state_d   = StRun;
          end else begin
            die_d = die_q + DIE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGameover: begin
        if (start_btn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      period_q   <= CNT_W'(BASE_TICKS);
      score_q    <= '0;
      level_q    <= '0;
      lives_q    <= 2'(LIVES);
      food_cnt_q <= '0;
      die_q      <= '0;
      dir_q      <= DIR_DEFAULT;
      eaten_q    <= 1'b0;
      tick_q     <= 1'b0;
      inc_q      <= 1'b0;
      rst_game_q <= 1'b0;
      respawn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      score_q    <= score_d;
      level_q    <= level_d;
      lives_q    <= lives_d;
      food_cnt_q <= food_cnt_d;
      die_q      <= die_d;
      dir_q      <= dir_d;
      eaten_q    <= eaten_d;
      tick_q     <= tick_d;
      inc_q      <= inc_d;
      rst_game_q <= rst_game_d;
      respawn_q  <= respawn_d;
    end
  end

  assign frame_tick    = tick_q;
  assign update_snake  = tick_q;
  assign score_inc     = inc_q;
  assign reset_game    = rst_game_q;
  assign respawn       = respawn_q;
  assign direction_out = dir_q;
  assign score         = score_q;
  assign level         = level_q;
  assign lives_left    = lives_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench for game_ctrl_fsm using small timing parameters so every
// frame period, level step and respawn can be counted cycle by cycle.
module tb_game_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_btn, pause_btn, dir_valid, food_eaten, collision;
  logic [1:0] dir_in;
  logic       frame_tick, update_snake, score_inc, reset_game, respawn;
  logic [1:0] direction_out, lives_left;
  logic [9:0] score;
  logic [3:0] level;
  logic [2:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;

  game_ctrl_fsm #(
    .BASE_TICKS    (10),
    .MIN_TICKS     (4),
    .STEP_TICKS    (2),
    .FOOD_PER_LEVEL(2),
    .MAX_LEVEL     (15),
    .LIVES         (2),
    .RESPAWN_FRAMES(2),
    .SCORE_W       (10),
    .CNT_W         (25)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_btn    (start_btn),
    .pause_btn    (pause_btn),
    .dir_valid    (dir_valid),
    .dir_in       (dir_in),
    .food_eaten   (food_eaten),
    .collision    (collision),
    .frame_tick   (frame_tick),
    .update_snake (update_snake),
    .score_inc    (score_inc),
    .reset_game   (reset_game),
    .respawn      (respawn),
    .direction_out(direction_out),
    .score        (score),
    .level        (level),
    .lives_left   (lives_left),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1; step(); start_btn = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
  endtask

  task automatic pulse_food();
    food_eaten = 1'b1; step(); food_eaten = 1'b0;
  endtask

  task automatic push_dir(input logic [1:0] d);
    dir_valid = 1'b1; dir_in = d; step(); dir_valid = 1'b0;
  endtask

  // Cycles until the next frame_tick; 200 means it never came.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 200);
  endtask

  int n;
  int ticks;

  initial begin
    rstn = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; dir_valid = 1'b0;
    dir_in = 2'b00; food_eaten = 1'b0; collision = 1'b0;
    #12;
    check_eq("rst_state", state_out, 0);
    check_eq("rst_dir", direction_out, 1);
    check_eq("rst_score", score, 0);
    check_eq("rst_lives", lives_left, 2);
    check_eq("rst_tick", frame_tick, 0);
    rstn = 1'b1;
    step();

    // Start and base tick spacing
    pulse_start();
    check_eq("start_reset_game", reset_game, 1);
    check_eq("start_state", state_out, 1);
    wait_tick(n);
    check_eq("first_tick_gap", n, 10);
    check_eq("update_snake", update_snake, 1);
    wait_tick(n);
    check_eq("tick_gap_l0", n, 10);
    check_eq("dir_default", direction_out, 1);
    check_eq("noinc_plain_tick", score_inc, 0);

    // Level speed-up
    pulse_food();
    wait_tick(n);
    check_eq("inc1", score_inc, 1);
    check_eq("score1", score, 1);
    pulse_food();
    wait_tick(n);
    check_eq("score2", score, 2);
    check_eq("level1", level, 1);
    wait_tick(n);
    check_eq("gap_before_recalc", n, 10);
    wait_tick(n);
    check_eq("gap_l1", n, 8);
    for (int i = 0; i < 4; i++) begin
      pulse_food();
      wait_tick(n);
    end
    check_eq("level3", level, 3);
    check_eq("score6", score, 6);
    wait_tick(n);
    check_eq("gap_l2", n, 6);
    wait_tick(n);
    check_eq("gap_l3", n, 4);
    for (int i = 0; i < 2; i++) begin
      pulse_food();
      wait_tick(n);
    end
    check_eq("level4", level, 4);
    wait_tick(n);
    wait_tick(n);
    check_eq("gap_l4_floor", n, 4);

    // Direction queue filled while paused
    pulse_pause();
    check_eq("paused", state_out, 2);
    push_dir(2'b11);
    push_dir(2'b00);
    push_dir(2'b11);
    push_dir(2'b10);
    pulse_pause();
    wait_tick(n);
    check_eq("gap_after_pause", n, 4);
    check_eq("q_pop1", direction_out, 0);
    wait_tick(n);
    check_eq("q_pop2", direction_out, 3);
    wait_tick(n);
    check_eq("q_third_dropped", direction_out, 3);

    // Collision with food latched
    pulse_food();
    collision = 1'b1;
    wait_tick(n);
    collision = 1'b0;
    check_eq("coll_noinc", score_inc, 0);
    check_eq("coll_score", score, 8);
    check_eq("coll_lives", lives_left, 1);
    check_eq("coll_state", state_out, 3);
    n = 0; ticks = 0;
    do begin
      step();
      n++;
      if (frame_tick) ticks++;
    end while (!respawn && n < 200);
    check_eq("respawn_gap", n, 8);
    check_eq("dying_no_ticks", ticks, 0);
    check_eq("respawn_state", state_out, 1);
    check_eq("respawn_dir", direction_out, 1);

    // Last life
    collision = 1'b1;
    wait_tick(n);
    collision = 1'b0;
    check_eq("last_gap", n, 4);
    check_eq("last_lives", lives_left, 0);
    check_eq("gameover_state", state_out, 4);
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (frame_tick) ticks++;
    end
    check_eq("gameover_no_ticks", ticks, 0);
    check_eq("gameover_score", score, 8);
    pulse_start();
    check_eq("gameover_to_idle", state_out, 0);
    pulse_start();
    check_eq("restart_reset_game", reset_game, 1);
    check_eq("restart_score", score, 0);
    check_eq("restart_lives", lives_left, 2);
    check_eq("restart_level", level, 0);

    // Pause mid-frame at counter 5
    repeat (5) step();
    pulse_pause();
    check_eq("pause2_state", state_out, 2);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (frame_tick) ticks++;
    end
    check_eq("pause_no_ticks", ticks, 0);
    pulse_pause();
    wait_tick(n);
    check_eq("resume_gap", n, 5);

    // Async reset while pulses are active
    pulse_food();
    wait_tick(n);
    check_eq("pre_rst_score", score, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("arst_tick", frame_tick, 0);
    check_eq("arst_inc", score_inc, 0);
    check_eq("arst_score", score, 0);
    check_eq("arst_state", state_out, 0);
    check_eq("arst_dir", direction_out, 1);
    check_eq("arst_lives", lives_left, 2);
    #10;
    rstn = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
